axis_frame_source: RTL and testbench
====================================

# axis_frame_source

- AXI4-Stream master that generates a deterministic test frame (lines × beats) for the byte-wise stream processing blocks, e.g. the pixel inverter.
- Sits at the upstream end of the stream chain.
- Holds data stable under back-pressure, marks end-of-line with TLAST, and reports busy/done to a control processor.
- The known pattern lets a downstream checker predict every output byte.

## Interface
- DATA_WIDTH, 32, stream data width in bits; multiple of 8; BYTES = DATA_WIDTH/8.
- axi_clk  in  1  single clock; all logic on rising edge.
- axi_rsr_m  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to emit one frame; honoured only in IDLE.
- cfg_line_beats  in  16  beats per line; sampled on accepted start.
- cfg_lines  in  16  lines per frame; sampled on accepted start.
- busy  out  1  high from the cycle after accepted start until DONE is left.
- done  out  1  one-cycle pulse after the final beat handshake.
- m_axis_valid  out  1  master valid.
- m_axis_data  out  DATA_WIDTH  master data.
- m_axis_last  out  1  high on the last beat of each line.
- m_axis_ready  in  1  slave ready.
- m_axis_user  out  1  start-of-frame flag; present only with AXIS_SRC_SOF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with both cfg values nonzero → latch cfg, clear col/row counters, go to RUN.
  - start=1 with either cfg value zero → go to DONE; no beats emitted.
- RUN:
  - m_axis_valid=1 throughout.
  - A beat transfers when m_axis_valid & m_axis_ready.
  - On transfer, col increments.
  - At col = line_beats-1, col wraps to 0 and row increments.
  - Transfer with col = line_beats-1 and row = lines-1 → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Data: byte lane i of beat = (col*BYTES + i + row) mod 256, all arithmetic truncated to 8 bits.
- m_axis_last = (col == line_beats-1).
- Back-pressure:
  - While valid=1 and ready=0, data/last/user hold unchanged.
  - Valid never deasserts before the handshake.
- start during RUN or DONE is ignored. Cfg changes after start do not affect the frame in progress.
- Reset value of every output is 0: valid, data, last, user, busy, done. State returns to IDLE and counters clear.
- Reset mid-frame abandons the frame; no done pulse is issued.

## Timing
- Accepted start at edge N → first beat valid from edge N+1.
- With ready held high: one beat per cycle, line_beats×lines consecutive valid cycles, no bubbles, including across line boundaries.
- done asserts in the cycle after the final handshake edge; busy falls on the same edge that done falls.
- Zero-size frame: busy and done both high for one cycle, from start edge +1.
- Earliest next accepted start: the cycle done is high is still DONE, so start is ignored; first acceptable start is the cycle after done.
- Outputs are registered; no combinational path from m_axis_ready to any output.

## Configuration
- AXIS_SRC_SOF_EN defined:
  - m_axis_user port exists.
  - m_axis_user=1 only on beat (row 0, col 0) of each frame; held with data under back-pressure; reset value 0.
- AXIS_SRC_SOF_EN undefined: port and its logic are absent; all other behaviour identical.

## Test plan
- Reset, then start with line_beats=4, lines=2, ready=1:
  - 8 consecutive beats.
  - Beat 0 data 0x03020100; beat 4 (row 1, col 0) 0x04030201.
  - last on beats 3 and 7; done one cycle after beat 7.
- Same frame, ready toggling 1,0,0,1,…: data/last stable across stalls; every beat appears exactly once, in order; total 8 handshakes.
- start with line_beats=0, lines=5: no valid ever; busy and done high together for one cycle; then IDLE.
- Pulse start mid-frame with different cfg: ignored; frame completes with original size; no second frame.
- Assert axi_rsr_m at beat 3 of a 4×2 frame:
  - next edge all outputs 0; no done pulse.
  - a new start then begins at data 0x03020100.
- With AXIS_SRC_SOF_EN, two back-to-back frames: m_axis_user=1 only on the first beat of each frame, including while that beat is stalled.

Source files
------------

// File: rtl/axis_frame_source_if.sv
// AXI4-Stream master/slave bundle for axis_frame_source.
// Carries TUSER (start-of-frame) only when AXIS_SRC_SOF_EN is defined.
interface axis_frame_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;
`ifdef AXIS_SRC_SOF_EN
  logic                  user;

  modport master (
    output valid, data, last, user,
    input  ready
  );

  modport slave (
    input  valid, data, last, user,
    output ready
  );
`else
  modport master (
    output valid, data, last,
    input  ready
  );

  modport slave (
    input  valid, data, last,
    output ready
  );
`endif
endinterface

// File: rtl/axis_frame_source.sv
// Deterministic lines x beats AXI4-Stream frame generator.
// Optional SOF flag on m_axis.user when AXIS_SRC_SOF_EN is defined.
module axis_frame_source #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 axi_clk,
  input  logic                 axi_rsr_m,
  input  logic                 start,
  input  logic [15:0]          cfg_line_beats,
  input  logic [15:0]          cfg_lines,
  output logic                 busy,
  output logic                 done,
  axis_frame_source_if.master  m_axis
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic [15:0]           lb_q, lb_d;
  logic [15:0]           ln_q, ln_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef AXIS_SRC_SOF_EN
  logic                  user_q, user_d;
`endif

  // Byte lane i = col*BYTES + i + row, everything truncated to 8 bits
  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [15:0] c,
    input logic [15:0] r
  );
    logic [7:0] base;
    pat  = '0;
    base = 8'(c * 16'(BYTES)) + r[7:0];
    for (int i = 0; i < BYTES; i++) begin
      pat[i*8 +: 8] = base + 8'(i);
    end
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    lb_d    = lb_q;
    ln_d    = ln_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef AXIS_SRC_SOF_EN
    user_d  = user_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lb_d   = cfg_line_beats;
          ln_d   = cfg_lines;
          col_d  = '0;
          row_d  = '0;
          busy_d = 1'b1;
          if (cfg_line_beats != '0 &&
              cfg_lines != '0) begin
            state_d = RUN;
            valid_d = 1'b1;
            data_d  = pat(16'd0, 16'd0);
            last_d  = (cfg_line_beats == 16'd1);
`ifdef AXIS_SRC_SOF_EN
            user_d  = 1'b1;
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (m_axis.ready) begin
`ifdef AXIS_SRC_SOF_EN
          user_d = 1'b0;
`endif
          if (col_q == lb_q - 16'd1) begin
            col_d = '0;
            if (row_q == ln_q - 16'd1) begin
              state_d = DONE;
              done_d  = 1'b1;
              valid_d = 1'b0;
              last_d  = 1'b0;
              data_d  = '0;
            end else begin
              row_d  = row_q + 16'd1;
              data_d = pat(16'd0, row_q + 16'd1);
              last_d = (lb_q == 16'd1);
            end
          end else begin
            col_d  = col_q + 16'd1;
            data_d = pat(col_q + 16'd1, row_q);
            last_d = (col_q + 16'd1 == lb_q - 16'd1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rsr_m) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      lb_q    <= '0;
      ln_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AXIS_SRC_SOF_EN
      user_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lb_q    <= lb_d;
      ln_q    <= ln_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AXIS_SRC_SOF_EN
      user_q  <= user_d;
`endif
    end
  end

  assign m_axis.valid = valid_q;
  assign m_axis.data  = data_q;
  assign m_axis.last  = last_q;
`ifdef AXIS_SRC_SOF_EN
  assign m_axis.user  = user_q;
`endif
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Scoreboard bench for axis_frame_source: stimulus pushes expected
// beats, a negedge monitor pops and checks every handshake.
module tb_axis_frame_source;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        u;
    logic        f;
  } exp_t;

  localparam logic [31:0] F42 [8] = '{
    32'h03020100, 32'h07060504,
    32'h0B0A0908, 32'h0F0E0D0C,
    32'h04030201, 32'h08070605,
    32'h0C0B0A09, 32'h100F0E0D
  };
  localparam logic [31:0] F21 [2] = '{
    32'h03020100, 32'h07060504
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_lb;
  logic [15:0] cfg_ln;
  logic        busy;
  logic        done;

  axis_frame_source_if #(.DATA_WIDTH(32)) axis ();

  axis_frame_source #(.DATA_WIDTH(32)) dut (
    .axi_clk        (clk),
    .axi_rsr_m      (rst),
    .start          (start),
    .cfg_line_beats (cfg_lb),
    .cfg_lines      (cfg_ln),
    .busy           (busy),
    .done           (done),
    .m_axis         (axis)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb [$];
  bit   in_reset = 1'b1;
  bit   done_due = 1'b0;
  bit   stalled  = 1'b0;
  int   hs       = 0;
  logic [31:0] p_d;
  logic        p_l;
  logic        p_u;

  function automatic logic cur_user();
`ifdef AXIS_SRC_SOF_EN
    return axis.user;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_d;
    if (!in_reset) begin
      exp_d    = done_due;
      done_due = 1'b0;
      if (done || exp_d) begin
        chk("done", done, exp_d);
        chk("busy_with_done", busy, 1);
      end
      if (stalled) begin
        chk("stall_valid", axis.valid, 1);
        chk("stall_data", axis.data, p_d);
        chk("stall_last", axis.last, p_l);
`ifdef AXIS_SRC_SOF_EN
        chk("stall_user", cur_user(), p_u);
`endif
      end
      stalled = 1'b0;
      if (axis.valid) begin
        if (axis.ready) begin
          hs++;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none",
                     axis.data);
          end else begin
            e = sb.pop_front();
            chk("beat_data", axis.data, e.d);
            chk("beat_last", axis.last, e.l);
`ifdef AXIS_SRC_SOF_EN
            chk("beat_user", cur_user(), e.u);
`endif
            if (e.f) done_due = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          p_d     = axis.data;
          p_l     = axis.last;
          p_u     = cur_user();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_42();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.d = F42[i];
      e.l = ((i % 4) == 3);
      e.u = (i == 0);
      e.f = (i == 7);
      sb.push_back(e);
    end
  endtask

  task automatic push_21();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.d = F21[i];
      e.l = (i == 1);
      e.u = (i == 0);
      e.f = (i == 1);
      sb.push_back(e);
    end
  endtask

  // Accept edge happens inside; returns #1 after it with cfg scrambled
  task automatic do_start(input logic [15:0] lb,
                          input logic [15:0] ln);
    start  = 1'b1;
    cfg_lb = lb;
    cfg_ln = ln;
    tick();
    start  = 1'b0;
    cfg_lb = 16'd7;
    cfg_ln = 16'd7;
  endtask

  task automatic wait_done(input logic [3:0] rp,
                           input int budget);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      axis.ready = rp[k % 4];
      tick();
      if (done) seen = 1'b1;
      k++;
    end
    axis.ready = 1'b1;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d",
               budget);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, axis.valid, 0);
    chk({nm, "_data"}, axis.data, 0);
    chk({nm, "_last"}, axis.last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
`ifdef AXIS_SRC_SOF_EN
    chk({nm, "_user"}, cur_user(), 0);
`endif
  endtask

  initial begin
    int h0;
    rst        = 1'b1;
    start      = 1'b0;
    cfg_lb     = '0;
    cfg_ln     = '0;
    axis.ready = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst      = 1'b0;
    in_reset = 1'b0;
    tick();

    // 4x2 frame, ready high: 8 beats back to back
    axis.ready = 1'b1;
    push_42();
    h0 = hs;
    do_start(16'd4, 16'd2);
    chk("busy_after_start", busy, 1);
    repeat (8) tick();
    chk("no_bubble_hs", hs - h0, 8);
    chk("done_after_last", done, 1);
    tick();
    chk("busy_fall", busy, 0);
    chk("done_fall", done, 0);
    chk("sb_empty_1", sb.size(), 0);

    // Same frame with ready 1,0,0,1
    push_42();
    h0 = hs;
    do_start(16'd4, 16'd2);
    wait_done(4'b1001, 200);
    tick();
    chk("toggle_hs", hs - h0, 8);
    chk("sb_empty_2", sb.size(), 0);

    // Zero-size frame
    do_start(16'd0, 16'd5);
    done_due = 1'b1;
    chk("zero_busy", busy, 1);
    chk("zero_valid", axis.valid, 0);
    tick();
    chk("zero_busy_fall", busy, 0);
    chk("zero_done_fall", done, 0);
    tick();
    chk("zero_idle_valid", axis.valid, 0);

    // Start mid-frame is ignored
    push_42();
    h0 = hs;
    do_start(16'd4, 16'd2);
    tick();
    tick();
    start  = 1'b1;
    cfg_lb = 16'd2;
    cfg_ln = 16'd1;
    tick();
    start  = 1'b0;
    wait_done(4'b1111, 100);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("no_second_frame", axis.valid, 0);
      tick();
    end
    chk("midstart_hs", hs - h0, 8);
    chk("sb_empty_3", sb.size(), 0);

    // Reset during beat 3
    push_42();
    do_start(16'd4, 16'd2);
    repeat (3) tick();
    chk("beat3_present", axis.data, 32'h0F0E0D0C);
    in_reset = 1'b1;
    rst      = 1'b1;
    tick();
    chk_all_zero("midreset");
    rst = 1'b0;
    sb.delete();
    done_due = 1'b0;
    stalled  = 1'b0;
    in_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_done_after_reset", done, 0);
      tick();
    end
    push_42();
    h0 = hs;
    do_start(16'd4, 16'd2);
    wait_done(4'b1111, 100);
    tick();
    chk("post_reset_hs", hs - h0, 8);

    // Back-to-back 2x1 frames, first beat stalled
    push_21();
    push_21();
    axis.ready = 1'b0;
    do_start(16'd2, 16'd1);
    tick();
    tick();
    wait_done(4'b1111, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", axis.valid, 0);
    axis.ready = 1'b0;
    do_start(16'd2, 16'd1);
    tick();
    wait_done(4'b1111, 50);
    tick();
    chk("sb_empty_final", sb.size(), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
